// File: rtl/wide_alu_arbiter.sv
// Round-robin arbiter that shares one wide_alu between NUM_REQ requesters and
// sequences each operation through config write, trigger, wait and error clear.
package wide_alu_pkg;
    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MUL = 3'd3,
        XOR = 3'd4,
        AND = 3'd5,
        OR  = 3'd6
    } optype_e;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PENDING      = 2'd1,
        ERROR_WRITE  = 2'd2,
        ERROR_OPCODE = 2'd3
    } status_e;
endpackage

module wide_alu_arbiter #(
    parameter int NUM_REQ               = 4,
    parameter int ALU_WIDTH             = 256,
    parameter int DEACCEL_COUNTER_WIDTH = 8,
    localparam int OP_W = $bits(wide_alu_pkg::optype_e),
    localparam int ST_W = $bits(wide_alu_pkg::status_e),
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0]           req_op_i,
    input  logic [NUM_REQ*ALU_WIDTH-1:0]      req_a_i,
    input  logic [NUM_REQ*ALU_WIDTH-1:0]      req_b_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [ID_W-1:0]                   rsp_id_o,
    output logic [2*ALU_WIDTH-1:0]            rsp_result_o,
    output logic                              rsp_err_o,
    input  logic [DEACCEL_COUNTER_WIDTH-1:0]  cfg_deaccel_i,
    output logic                              alu_trigger_o,
    output logic                              alu_clear_err_o,
    output logic [ALU_WIDTH-1:0]              alu_op_a_o,
    output logic [ALU_WIDTH-1:0]              alu_op_b_o,
    output logic                              alu_op_sel_we_o,
    output logic [OP_W-1:0]                   alu_op_sel_o,
    output logic                              alu_deaccel_we_o,
    output logic [DEACCEL_COUNTER_WIDTH-1:0]  alu_deaccel_o,
    input  logic [2*ALU_WIDTH-1:0]            alu_result_i,
    input  logic [ST_W-1:0]                   alu_status_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_TRIG,
        S_WAIT,
        S_CLR,
        S_RESP
    } state_e;

    state_e                   state_reg, state_next;
    logic [ID_W-1:0]          ptr_reg, ptr_next;
    logic [ID_W-1:0]          grant_id_reg, grant_id_next;
    logic [OP_W-1:0]          op_reg, op_next;
    logic [ALU_WIDTH-1:0]     a_reg, a_next;
    logic [ALU_WIDTH-1:0]     b_reg, b_next;
    logic [2*ALU_WIDTH-1:0]   result_reg, result_next;
    logic                     err_reg, err_next;

    logic [OP_W-1:0]          op_arr [NUM_REQ];
    logic [ALU_WIDTH-1:0]     a_arr  [NUM_REQ];
    logic [ALU_WIDTH-1:0]     b_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]       mask_hi;
    logic [NUM_REQ-1:0]       valid_hi;
    logic                     grant_found;
    logic [ID_W-1:0]          grant_idx;
    logic                     alu_idle;
    logic                     alu_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]  = req_op_i[gi*OP_W +: OP_W];
            assign a_arr[gi]   = req_a_i[gi*ALU_WIDTH +: ALU_WIDTH];
            assign b_arr[gi]   = req_b_i[gi*ALU_WIDTH +: ALU_WIDTH];
            assign mask_hi[gi] = (gi >= int'(ptr_reg));
        end
    endgenerate

    assign valid_hi = req_valid_i & mask_hi;

    // Lowest valid index at or after the pointer; otherwise wrap to the lowest valid overall.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_hi[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign alu_idle = (alu_status_i == wide_alu_pkg::IDLE);
    assign alu_err  = (alu_status_i == wide_alu_pkg::ERROR_WRITE) ||
                      (alu_status_i == wide_alu_pkg::ERROR_OPCODE);

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_id_next    = grant_id_reg;
        op_next          = op_reg;
        a_next           = a_reg;
        b_next           = b_reg;
        result_next      = result_reg;
        err_next         = err_reg;
        req_ready_o      = '0;
        rsp_valid_o      = 1'b0;
        alu_trigger_o    = 1'b0;
        alu_clear_err_o  = 1'b0;
        alu_op_a_o       = '0;
        alu_op_b_o       = '0;
        alu_op_sel_we_o  = 1'b0;
        alu_op_sel_o     = '0;
        alu_deaccel_we_o = 1'b0;
        alu_deaccel_o    = '0;

        case (state_reg)
            S_IDLE: begin
                // Suppressed while reset is asserted so no request is acked and then discarded.
                if (!rst_i) begin
                    if (alu_err) begin
                        alu_clear_err_o = 1'b1;
                    end else if (alu_idle && grant_found) begin
                        req_ready_o   = NUM_REQ'(1) << grant_idx;
                        grant_id_next = grant_idx;
                        op_next       = op_arr[grant_idx];
                        a_next        = a_arr[grant_idx];
                        b_next        = b_arr[grant_idx];
                        state_next    = S_CFG;
                    end
                end
            end
            S_CFG: begin
                alu_op_a_o       = a_reg;
                alu_op_b_o       = b_reg;
                alu_op_sel_we_o  = 1'b1;
                alu_op_sel_o     = op_reg;
                alu_deaccel_we_o = 1'b1;
                alu_deaccel_o    = (cfg_deaccel_i == '0) ? DEACCEL_COUNTER_WIDTH'(1) : cfg_deaccel_i;
                state_next       = S_TRIG;
            end
            S_TRIG: begin
                alu_op_a_o    = a_reg;
                alu_op_b_o    = b_reg;
                alu_trigger_o = 1'b1;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                alu_op_a_o = a_reg;
                alu_op_b_o = b_reg;
                if (alu_idle) begin
                    result_next = alu_result_i;
                    err_next    = 1'b0;
                    state_next  = S_RESP;
                end else if (alu_err) begin
                    result_next = '0;
                    err_next    = 1'b1;
                    state_next  = S_CLR;
                end
            end
            S_CLR: begin
                alu_clear_err_o = 1'b1;
                state_next      = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    ptr_next   = (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rsp_id_o     = rsp_valid_o ? grant_id_reg : '0;
    assign rsp_result_o = rsp_valid_o ? result_reg : '0;
    assign rsp_err_o    = rsp_valid_o & err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            grant_id_reg <= '0;
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            grant_id_reg <= grant_id_next;
            op_reg       <= op_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            result_reg   <= result_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_wide_alu_arbiter.sv
// Bench for wide_alu_arbiter: behavioural wide_alu model plus a transaction-level
// round-robin scoreboard checked every cycle, with directed and random stimulus.
module tb_wide_alu_arbiter;
    localparam int N  = 4;
    localparam int W  = 256;
    localparam int DW = 8;
    localparam int RW = 2 * W;
    localparam int IW = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_EW   = 2'd2;
    localparam logic [1:0] ST_EOP  = 2'd3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*3-1:0]    req_op = '0;
    logic [N*W-1:0]    req_a = '0;
    logic [N*W-1:0]    req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [RW-1:0]     rsp_result;
    logic              rsp_err;
    logic [DW-1:0]     cfg_deaccel = 8'd1;
    logic              alu_trigger, alu_clear_err;
    logic [W-1:0]      alu_op_a, alu_op_b;
    logic              alu_op_sel_we, alu_deaccel_we;
    logic [2:0]        alu_op_sel;
    logic [DW-1:0]     alu_deaccel;
    logic [RW-1:0]     alu_result;
    logic [1:0]        alu_status;
    logic              inject_err = 1'b0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    wide_alu_arbiter #(
        .NUM_REQ(N), .ALU_WIDTH(W), .DEACCEL_COUNTER_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .cfg_deaccel_i(cfg_deaccel),
        .alu_trigger_o(alu_trigger), .alu_clear_err_o(alu_clear_err),
        .alu_op_a_o(alu_op_a), .alu_op_b_o(alu_op_b),
        .alu_op_sel_we_o(alu_op_sel_we), .alu_op_sel_o(alu_op_sel),
        .alu_deaccel_we_o(alu_deaccel_we), .alu_deaccel_o(alu_deaccel),
        .alu_result_i(alu_result), .alu_status_i(alu_status)
    );

    function automatic logic [RW-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [RW-1:0] ea;
        logic [RW-1:0] eb;
        ea = RW'(a);
        eb = RW'(b);
        case (op)
            3'd1: return ea + eb;
            3'd2: return ea - eb;
            3'd3: return ea * eb;
            3'd4: return ea ^ eb;
            3'd5: return ea & eb;
            3'd6: return ea | eb;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [2:0] rand_op();
        if ($urandom_range(0, 9) == 0) return 3'd7;
        return 3'($urandom_range(1, 6));
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural wide_alu: D cycles PENDING after trigger, errors on bad opcode or illegal write.
    logic [1:0]    alu_st = ST_IDLE;
    int            alu_cnt = 0;
    logic [RW-1:0] alu_res_q = '0;
    logic [2:0]    alu_op_q = 3'd1;
    logic [DW-1:0] alu_dea_q = 8'd1;
    int            clr_cnt = 0;
    int            err_write_cnt = 0;

    assign alu_status = alu_st;
    assign alu_result = alu_res_q;

    always @(posedge clk_i) begin
        if (alu_clear_err) clr_cnt <= clr_cnt + 1;
        if (inject_err && alu_st == ST_IDLE) begin
            alu_st <= ST_EOP;
        end else if (alu_clear_err && (alu_st == ST_EW || alu_st == ST_EOP)) begin
            alu_st <= ST_IDLE;
        end else if ((alu_op_sel_we || alu_deaccel_we) &&
                     (alu_st == ST_PEND || (alu_deaccel_we && alu_deaccel == '0))) begin
            alu_st        <= ST_EW;
            err_write_cnt <= err_write_cnt + 1;
        end else begin
            if (alu_op_sel_we) alu_op_q <= alu_op_sel;
            if (alu_deaccel_we) alu_dea_q <= alu_deaccel;
            if (alu_trigger && alu_st == ST_IDLE) begin
                if (alu_op_q == 3'd0 || alu_op_q == 3'd7) begin
                    alu_st <= ST_EOP;
                end else begin
                    alu_st    <= ST_PEND;
                    alu_cnt   <= int'(alu_dea_q);
                    alu_res_q <= ref_op(alu_op_q, alu_op_a, alu_op_b);
                end
            end else if (alu_st == ST_PEND) begin
                if (alu_cnt <= 1) alu_st <= ST_IDLE;
                else alu_cnt <= alu_cnt - 1;
            end
        end
    end

    // Transaction-level scoreboard: one outstanding op, round-robin pointer, fixed latency.
    bit            m_busy = 0;
    int            m_ptr = 0;
    int            m_g = 0;
    int            m_start = 0;
    int            m_lat = 0;
    logic [RW-1:0] m_res = '0;
    logic          m_err = 1'b0;
    int            ccount = 0;

    always @(negedge clk_i) begin
        int eg;
        logic [N-1:0] exp_ready;
        logic [2:0] op;
        int d;
        ccount++;
        eg = -1;
        if (!rst_i && !m_busy && alu_status == ST_IDLE) begin
            for (int j = 0; j < N; j++) begin
                if (eg < 0 && req_valid[(m_ptr + j) % N]) eg = (m_ptr + j) % N;
            end
        end
        exp_ready = (eg >= 0) ? (N'(1) << eg) : '0;
        check("grant", RW'(req_ready), RW'(exp_ready));
        if (!m_busy) begin
            check("clear_err_idle", RW'(alu_clear_err),
                  RW'(!rst_i && (alu_status == ST_EW || alu_status == ST_EOP)));
            check("rsp_valid_idle", RW'(rsp_valid), '0);
        end else begin
            check("rsp_valid", RW'(rsp_valid), RW'(ccount >= m_start + m_lat));
            if (rsp_valid) begin
                check("rsp_id", RW'(rsp_id), RW'(m_g));
                check("rsp_result", rsp_result, m_res);
                check("rsp_err", RW'(rsp_err), RW'(m_err));
                if (rsp_ready) begin
                    $display("txn id=%0d err=%0d latency=%0d result=%0h", rsp_id, rsp_err,
                             ccount - m_start, rsp_result);
                    m_busy = 0;
                    m_ptr  = (m_g + 1) % N;
                end
            end
        end
        if (eg >= 0) begin
            op      = req_op[eg*3 +: 3];
            d       = (cfg_deaccel == '0) ? 1 : int'(cfg_deaccel);
            m_busy  = 1;
            m_g     = eg;
            m_start = ccount;
            m_err   = (op == 3'd0 || op == 3'd7);
            m_res   = m_err ? '0 : ref_op(op, req_a[eg*W +: W], req_b[eg*W +: W]);
            m_lat   = m_err ? 5 : 4 + d;
        end
        if (rst_i) begin
            m_busy = 0;
            m_ptr  = 0;
        end
    end

    task automatic load_req(input int idx, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[idx*3 +: 3] = op;
        req_a[idx*W +: W]  = a;
        req_b[idx*W +: W]  = b;
    endtask

    task automatic wait_accept(input int idx, output int t0);
        bit got;
        got = 0;
        t0  = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk_i);
            if (req_ready[idx]) begin
                got = 1;
                t0  = cyc;
            end
        end
        check("accept_timeout", RW'(got), RW'(1));
        @(posedge clk_i);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic run_op(input int idx, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [RW-1:0] res, output logic err, output int id, output int lat);
        int t0;
        bit got;
        load_req(idx, op, a, b);
        req_valid[idx] = 1'b1;
        wait_accept(idx, t0);
        got = 0;
        lat = -1;
        res = '0;
        err = 1'b0;
        id  = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk_i);
            if (rsp_valid) begin
                got = 1;
                lat = cyc - t0;
                res = rsp_result;
                err = rsp_err;
                id  = int'(rsp_id);
            end
        end
        check("rsp_timeout", RW'(got), RW'(1));
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, RW'({req_ready, rsp_valid, rsp_id, rsp_err, alu_trigger, alu_clear_err,
                                    alu_op_sel_we, alu_op_sel, alu_deaccel_we, alu_deaccel}), '0);
        check({name, "_result"}, rsp_result, '0);
        check({name, "_operands"}, {alu_op_a, alu_op_b}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] res;
        logic [RW-1:0] two256;
        logic [RW-1:0] snap_res;
        logic          err;
        logic          snap_err;
        int            id, lat, t0, c0, snap_id;
        int            order[5];
        int            exp_rr[5];
        bit            got;
        logic [N-1:0]  last_ready;
        logic          last_rsp;

        two256 = RW'(1) << 256;
        exp_rr = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i);
        #1;

        // Single op: ADD (2^256-1) + 1
        run_op(0, 3'd1, {W{1'b1}}, W'(1), res, err, id, lat);
        check("single_result", res, two256);
        check("single_id", RW'(id), RW'(0));
        check("single_err", RW'(err), '0);
        check("single_latency", RW'(lat), RW'(5));

        run_op(3, 3'd3, W'(3), W'(5), res, err, id, lat);
        check("mul_result", res, RW'(15));
        check("mul_id", RW'(id), RW'(3));

        // Round-robin with all four requesters continuously valid
        for (int i = 0; i < N; i++) load_req(i, 3'($urandom_range(1, 6)), rand_w(), rand_w());
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            got = 0;
            order[g] = -1;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk_i);
                if (req_ready != '0) begin
                    got = 1;
                    for (int i = 0; i < N; i++) if (req_ready[i]) order[g] = i;
                end
            end
            check("rr_timeout", RW'(got), RW'(1));
            @(posedge clk_i);
            #1;
            if (order[g] >= 0) load_req(order[g], 3'($urandom_range(1, 6)), rand_w(), rand_w());
        end
        req_valid = '0;
        for (int g = 0; g < 5; g++) check($sformatf("rr_order_%0d", g), RW'(order[g]), RW'(exp_rr[g]));
        repeat (20) @(posedge clk_i);
        #1;

        // Deaccel factor 0 is clamped to 1
        cfg_deaccel = 8'd0;
        run_op(1, 3'd1, W'(7), W'(8), res, err, id, lat);
        check("deaccel0_latency", RW'(lat), RW'(5));
        check("deaccel0_result", res, RW'(15));
        cfg_deaccel = 8'd5;
        run_op(1, 3'd2, W'(20), W'(5), res, err, id, lat);
        check("deaccel5_latency", RW'(lat), RW'(9));
        check("deaccel5_result", res, RW'(15));
        cfg_deaccel = 8'd1;

        // Bad opcode
        c0 = clr_cnt;
        run_op(2, 3'd7, W'(9), W'(9), res, err, id, lat);
        check("badop_id", RW'(id), RW'(2));
        check("badop_err", RW'(err), RW'(1));
        check("badop_result", res, '0);
        check("badop_clear_pulses", RW'(clr_cnt - c0), RW'(1));
        run_op(3, 3'd3, W'(3), W'(5), res, err, id, lat);
        check("after_badop_result", res, RW'(15));
        check("after_badop_err", RW'(err), '0);

        // Stale ALU error while idle is cleared before the next grant
        inject_err = 1'b1;
        @(posedge clk_i);
        #1;
        inject_err = 1'b0;
        c0 = clr_cnt;
        run_op(0, 3'd4, W'(12), W'(10), res, err, id, lat);
        check("stale_clear_pulses", RW'(clr_cnt - c0), RW'(1));
        check("stale_result", res, RW'(6));

        // Backpressure: response held for 10 cycles, no new grant
        rsp_ready = 1'b0;
        load_req(0, 3'd1, W'(100), W'(23));
        req_valid[0] = 1'b1;
        wait_accept(0, t0);
        load_req(1, 3'd4, rand_w(), rand_w());
        req_valid[1] = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_i);
            if (rsp_valid) got = 1;
        end
        check("bp_rsp_timeout", RW'(got), RW'(1));
        snap_id  = int'(rsp_id);
        snap_res = rsp_result;
        snap_err = rsp_err;
        check("bp_result", snap_res, RW'(123));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            check("bp_valid_held", RW'(rsp_valid), RW'(1));
            check("bp_stable", {rsp_result[RW-4:0], rsp_err, IW'(rsp_id)},
                  {snap_res[RW-4:0], snap_err, IW'(snap_id)});
            check("bp_no_grant", RW'(req_ready), '0);
        end
        @(posedge clk_i);
        #1;
        rsp_ready = 1'b1;
        wait_accept(1, t0);
        repeat (10) @(posedge clk_i);
        #1;

        // Reset in the middle of WAIT drops the op
        cfg_deaccel = 8'd20;
        load_req(2, 3'd1, W'(1), W'(1));
        req_valid[2] = 1'b1;
        wait_accept(2, t0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("midreset");
        @(posedge clk_i);
        #1;
        cfg_deaccel = 8'd1;
        run_op(1, 3'd5, W'(12), W'(10), res, err, id, lat);
        check("postreset_result", res, RW'(8));
        check("postreset_id", RW'(id), RW'(1));
        check("postreset_latency", RW'(lat), RW'(5));

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_i);
            last_ready = req_ready;
            last_rsp   = rsp_valid;
            @(posedge clk_i);
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (last_ready[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    load_req(i, rand_op(), rand_w(), rand_w());
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        load_req(i, rand_op(), rand_w(), rand_w());
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (last_rsp && $urandom_range(0, 1) == 1) cfg_deaccel = DW'($urandom_range(0, 4));
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;

        check("no_error_write", RW'(err_write_cnt), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
